// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: datapath word width, PC increment, the fetch
// FSM state encoding and a word-alignment helper.
package cpu_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        FETCH_BOOT = 2'd0,
        FETCH_RUN  = 2'd1,
        FETCH_HALT = 2'd2
    } fetch_state_t;

    function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
        return {addr[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_register.sv
// Generic pipeline register: instruction word, PC+4 and valid bit, with
// flush and hold controls. Reusable for the later pipeline stages.
//
// Ports:
//   i_clk, i_rst_n         clock, async active-low reset
//   i_flush                load a bubble (valid=0, all data 0); beats hold
//   i_hold                 keep current contents
//   i_load                 capture i_instr / i_pc_plus4 and set valid
//   i_instr, i_pc_plus4    incoming payload
//   o_instr, o_pc_plus4    registered payload
//   o_valid                register holds a real instruction
module if_id_register
    import cpu_pkg::*;
#(
    parameter int W = WORD_W
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_flush,
    input  logic         i_hold,
    input  logic         i_load,
    input  logic [W-1:0] i_instr,
    input  logic [W-1:0] i_pc_plus4,
    output logic [W-1:0] o_instr,
    output logic [W-1:0] o_pc_plus4,
    output logic         o_valid
);

    logic [W-1:0] r_instr;
    logic [W-1:0] r_pc_plus4;
    logic         r_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_instr    <= '0;
            r_pc_plus4 <= '0;
            r_valid    <= 1'b0;
        end else if (i_flush) begin
            r_instr    <= '0;
            r_pc_plus4 <= '0;
            r_valid    <= 1'b0;
        end else if (!i_hold && i_load) begin
            r_instr    <= i_instr;
            r_pc_plus4 <= i_pc_plus4;
            r_valid    <= 1'b1;
        end
    end

    assign o_instr    = r_instr;
    assign o_pc_plus4 = r_pc_plus4;
    assign o_valid    = r_valid;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: program counter, fetch FSM and IF/ID register.
// Optional macro IF_BOUNDS_CHECK_EN enables the instruction-memory bounds
// check (sticky FetchFault, HALT state). Without it FetchFault is 0.
//
// state | meaning
// BOOT  | first cycle after reset release; no capture, PC holds
// RUN   | normal fetch (redirect > stall > fault > flush > fetch)
// HALT  | bounds fault taken; PC frozen, IF/ID empty, left only by reset
//
// Ports:
//   Clk, Rst               clock, async active-low reset
//   Stall, Flush           hazard hold / squash of IF/ID
//   Redirect, RedirectPC   taken branch/jump target from EX
//   ImemAddress            byte address to instruction memory (= PC)
//   ImemInstruction        combinational read data for ImemAddress
//   IfIdInstruction, IfIdPCPlus4, IfIdValid   IF/ID register to decode
//   FetchFault             sticky out-of-range fetch flag
module if_fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 396
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic [31:0] ImemAddress,
    input  logic [31:0] ImemInstruction,
    output logic [31:0] IfIdInstruction,
    output logic [31:0] IfIdPCPlus4,
    output logic        IfIdValid,
    output logic        FetchFault
);

    localparam logic [31:0] IMEM_WORDS_L = 32'(IMEM_WORDS);

    logic [31:0]  r_pc;
    fetch_state_t r_state;
    logic [31:0]  w_pc_plus4;
    logic         w_run;
    logic         w_fault_now;
    logic         w_flush_ifid;
    logic         w_hold_ifid;
    logic         w_load_ifid;

    assign w_pc_plus4 = r_pc + PC_STEP;
    assign w_run      = (r_state == FETCH_RUN);

`ifdef IF_BOUNDS_CHECK_EN
    logic r_fault;
    // A redirect target is only checked once it is actually fetched.
    assign w_fault_now = w_run && !Redirect && !Stall
                         && ({2'b00, r_pc[31:2]} >= IMEM_WORDS_L);
    assign FetchFault  = r_fault;
`else
    logic w_unused_imem_words;
    assign w_unused_imem_words = |IMEM_WORDS_L;
    assign w_fault_now = 1'b0;
    assign FetchFault  = 1'b0;
`endif

    // Redirect outranks stall, so a redirect also squashes a stalled IF/ID.
    assign w_flush_ifid = w_run && (Redirect || Flush || w_fault_now);
    assign w_hold_ifid  = !w_run || Stall;
    assign w_load_ifid  = w_run && !Redirect && !Stall && !Flush && !w_fault_now;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_pc    <= word_align(RESET_PC);
            r_state <= FETCH_BOOT;
`ifdef IF_BOUNDS_CHECK_EN
            r_fault <= 1'b0;
`endif
        end else begin
            case (r_state)
                FETCH_BOOT: r_state <= FETCH_RUN;
                FETCH_RUN: begin
                    if (Redirect) begin
                        r_pc <= word_align(RedirectPC);
                    end else if (Stall) begin
                        r_pc <= r_pc;
`ifdef IF_BOUNDS_CHECK_EN
                    end else if (w_fault_now) begin
                        r_fault <= 1'b1;
                        r_state <= FETCH_HALT;
`endif
                    end else begin
                        r_pc <= w_pc_plus4;
                    end
                end
`ifdef IF_BOUNDS_CHECK_EN
                FETCH_HALT: r_state <= FETCH_HALT;
`endif
                default: r_state <= FETCH_BOOT;
            endcase
        end
    end

    assign ImemAddress = r_pc;

    if_id_register #(.W(WORD_W)) u_if_id (
        .i_clk      (Clk),
        .i_rst_n    (Rst),
        .i_flush    (w_flush_ifid),
        .i_hold     (w_hold_ifid),
        .i_load     (w_load_ifid),
        .i_instr    (ImemInstruction),
        .i_pc_plus4 (w_pc_plus4),
        .o_instr    (IfIdInstruction),
        .o_pc_plus4 (IfIdPCPlus4),
        .o_valid    (IfIdValid)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          IMEM_WORDS = 396;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        Stall = 1'b0;
    logic        Flush = 1'b0;
    logic        Redirect = 1'b0;
    logic [31:0] RedirectPC = '0;
    logic [31:0] ImemAddress;
    logic [31:0] ImemInstruction;
    logic [31:0] IfIdInstruction;
    logic [31:0] IfIdPCPlus4;
    logic        IfIdValid;
    logic        FetchFault;

    logic [31:0] mem [0:1023];
    assign ImemInstruction = mem[ImemAddress[11:2]];

    always #5 Clk = ~Clk;

    if_fetch_stage #(.RESET_PC(RESET_PC), .IMEM_WORDS(IMEM_WORDS)) dut (
        .Clk             (Clk),
        .Rst             (Rst),
        .Stall           (Stall),
        .Flush           (Flush),
        .Redirect        (Redirect),
        .RedirectPC      (RedirectPC),
        .ImemAddress     (ImemAddress),
        .ImemInstruction (ImemInstruction),
        .IfIdInstruction (IfIdInstruction),
        .IfIdPCPlus4     (IfIdPCPlus4),
        .IfIdValid       (IfIdValid),
        .FetchFault      (FetchFault)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: architectural view of the fetch stage.
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid, m_boot, m_halt, m_fault;

`ifdef IF_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    task automatic model_reset();
        m_pc = RESET_PC; m_instr = 0; m_pc4 = 0; m_valid = 0;
        m_boot = 1; m_halt = 0; m_fault = 0;
    endtask

    task automatic model_bubble();
        m_instr = 0; m_pc4 = 0; m_valid = 0;
    endtask

    task automatic model_edge();
        if (m_boot) begin
            m_boot = 0;
        end else if (m_halt) begin
            // frozen until reset
        end else if (Redirect) begin
            m_pc = RedirectPC & 32'hFFFF_FFFC;
            model_bubble();
        end else if (Stall) begin
            if (Flush) model_bubble();
        end else if (BOUNDS && (m_pc >> 2) >= IMEM_WORDS) begin
            m_fault = 1; m_halt = 1;
            model_bubble();
        end else if (Flush) begin
            m_pc = m_pc + 4;
            model_bubble();
        end else begin
            m_instr = mem[m_pc[11:2]];
            m_pc4   = m_pc + 4;
            m_valid = 1;
            m_pc    = m_pc + 4;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_inputs();
        Stall = 0; Flush = 0; Redirect = 0; RedirectPC = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        Rst = 0;
        #2;
        model_reset();
        @(posedge Clk);
        #1;
        Rst = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        Rst = 0;
        model_reset();
        #7;
        checks++;
        if (ImemAddress !== RESET_PC || IfIdInstruction !== 0 || IfIdPCPlus4 !== 0 ||
            IfIdValid !== 0 || FetchFault !== 0) begin
            errors++;
            $display("FAIL reset_state addr=%h instr=%h pc4=%h valid=%b fault=%b required addr=%h rest 0",
                     ImemAddress, IfIdInstruction, IfIdPCPlus4, IfIdValid, FetchFault, RESET_PC);
        end
        @(posedge Clk);
        #1;
        Rst = 1;
    endtask

    task automatic test_boot_sequence();
        logic [31:0] exp_i [3];
        exp_i[0] = 32'h2008_0001; exp_i[1] = 32'h2009_0002; exp_i[2] = 32'h0109_5020;
        do_reset();
        step();
        checks++;
        if (IfIdValid !== 1'b0 || ImemAddress !== 32'h0) begin
            errors++;
            $display("FAIL boot_cycle valid=%b addr=%h required valid=0 addr=0", IfIdValid, ImemAddress);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (IfIdInstruction !== exp_i[k] || IfIdPCPlus4 !== 32'(4 * (k + 1)) || IfIdValid !== 1'b1) begin
                errors++;
                $display("FAIL boot_fetch%0d instr=%h pc4=%h valid=%b required instr=%h pc4=%h valid=1",
                         k, IfIdInstruction, IfIdPCPlus4, IfIdValid, exp_i[k], 32'(4 * (k + 1)));
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        step(); step(); step();  // boot + 2 fetches, PC = 0x8
        Stall = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (ImemAddress !== 32'h8 || IfIdInstruction !== mem[1] || IfIdPCPlus4 !== 32'h8 || IfIdValid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold%0d addr=%h instr=%h pc4=%h valid=%b required addr=8 instr=%h pc4=8 valid=1",
                         k, ImemAddress, IfIdInstruction, IfIdPCPlus4, IfIdValid, mem[1]);
            end
        end
        Stall = 0;
        step();
        checks++;
        if (IfIdPCPlus4 !== 32'hC || IfIdInstruction !== mem[2]) begin
            errors++;
            $display("FAIL stall_release pc4=%h instr=%h required pc4=c instr=%h", IfIdPCPlus4, IfIdInstruction, mem[2]);
        end
    endtask

    task automatic test_redirect_stall();
        do_reset();
        step(); step(); step();
        Redirect = 1; RedirectPC = 32'h43; Stall = 1;
        step();
        checks++;
        if (ImemAddress !== 32'h40 || IfIdValid !== 1'b0 || IfIdInstruction !== 32'h0 || IfIdPCPlus4 !== 32'h0) begin
            errors++;
            $display("FAIL redirect_flush addr=%h valid=%b instr=%h pc4=%h required addr=40 valid=0 instr=0 pc4=0",
                     ImemAddress, IfIdValid, IfIdInstruction, IfIdPCPlus4);
        end
        clear_inputs();
        step();
        checks++;
        if (IfIdInstruction !== mem[16] || IfIdPCPlus4 !== 32'h44 || IfIdValid !== 1'b1) begin
            errors++;
            $display("FAIL redirect_fetch instr=%h pc4=%h valid=%b required instr=%h pc4=44 valid=1",
                     IfIdInstruction, IfIdPCPlus4, IfIdValid, mem[16]);
        end
    endtask

    task automatic test_flush_stall();
        do_reset();
        for (int k = 0; k < 5; k++) step();  // PC = 0x10
        Stall = 1; Flush = 1;
        step();
        checks++;
        if (ImemAddress !== 32'h10 || IfIdValid !== 1'b0 || IfIdInstruction !== 32'h0) begin
            errors++;
            $display("FAIL flush_stall addr=%h valid=%b instr=%h required addr=10 valid=0 instr=0",
                     ImemAddress, IfIdValid, IfIdInstruction);
        end
        clear_inputs();
        step();
        checks++;
        if (IfIdInstruction !== mem[4] || IfIdPCPlus4 !== 32'h14 || IfIdValid !== 1'b1) begin
            errors++;
            $display("FAIL flush_refetch instr=%h pc4=%h valid=%b required instr=%h pc4=14 valid=1",
                     IfIdInstruction, IfIdPCPlus4, IfIdValid, mem[4]);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int k = 0; k < 10; k++) step();  // PC = 0x24
        checks++;
        if (ImemAddress !== 32'h24) begin
            errors++;
            $display("FAIL pre_async_pc addr=%h required 24", ImemAddress);
        end
        #2;
        Rst = 0;
        model_reset();
        #1;
        checks++;
        if (ImemAddress !== RESET_PC || IfIdInstruction !== 0 || IfIdPCPlus4 !== 0 ||
            IfIdValid !== 0 || FetchFault !== 0) begin
            errors++;
            $display("FAIL async_reset addr=%h instr=%h pc4=%h valid=%b fault=%b required all 0",
                     ImemAddress, IfIdInstruction, IfIdPCPlus4, IfIdValid, FetchFault);
        end
        @(posedge Clk);
        #1;
        Rst = 1;
    endtask

    task automatic test_wrap();
        do_reset();
        step();
        Redirect = 1; RedirectPC = 32'hFFFF_FFFE;
        step();
        clear_inputs();
        step();
        checks++;
        if (ImemAddress !== m_pc || IfIdPCPlus4 !== m_pc4 || IfIdValid !== m_valid || FetchFault !== m_fault) begin
            errors++;
            $display("FAIL wrap addr=%h pc4=%h valid=%b fault=%b required addr=%h pc4=%h valid=%b fault=%b",
                     ImemAddress, IfIdPCPlus4, IfIdValid, FetchFault, m_pc, m_pc4, m_valid, m_fault);
        end
    endtask

    task automatic test_bounds();
        do_reset();
        step();
        Redirect = 1; RedirectPC = 32'h62C;
        step();
        clear_inputs();
        step();  // fetches word 395, PC moves to 0x630
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (FetchFault !== m_fault || ImemAddress !== m_pc || IfIdValid !== m_valid) begin
                errors++;
                $display("FAIL bounds%0d fault=%b addr=%h valid=%b required fault=%b addr=%h valid=%b",
                         k, FetchFault, ImemAddress, IfIdValid, m_fault, m_pc, m_valid);
            end
        end
        checks++;
        if (FetchFault !== BOUNDS) begin
            errors++;
            $display("FAIL bounds_flag fault=%b required %b", FetchFault, BOUNDS);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            Stall    = ($urandom_range(0, 99) < 25);
            Flush    = ($urandom_range(0, 99) < 15);
            Redirect = ($urandom_range(0, 99) < 10);
            if ($urandom_range(0, 99) < 3) RedirectPC = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else RedirectPC = 32'($urandom_range(0, 32'h5FF));
            step();
            checks++;
            if (ImemAddress !== m_pc || IfIdInstruction !== m_instr || IfIdPCPlus4 !== m_pc4 ||
                IfIdValid !== m_valid || FetchFault !== m_fault) begin
                errors++;
                $display("FAIL random%0d addr=%h instr=%h pc4=%h valid=%b fault=%b required addr=%h instr=%h pc4=%h valid=%b fault=%b",
                         n, ImemAddress, IfIdInstruction, IfIdPCPlus4, IfIdValid, FetchFault,
                         m_pc, m_instr, m_pc4, m_valid, m_fault);
            end
        end
        clear_inputs();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[0] = 32'h2008_0001;
        mem[1] = 32'h2009_0002;
        mem[2] = 32'h0109_5020;
        test_reset();
        test_boot_sequence();
        test_stall();
        test_redirect_stall();
        test_flush_stall();
        test_async_reset();
        test_wrap();
        test_bounds();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
